// File: rtl/sdram_sample_player_pkg.sv
// Shared encodings for the SDRAM sample playback path: FSM states, speed codes
// and the fetch address step associated with each speed.
package sdram_sample_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SPD_1X   = 2'd0;
    localparam logic [1:0] SPD_2X   = 2'd1;
    localparam logic [1:0] SPD_4X   = 2'd2;
    localparam logic [1:0] SPD_HALF = 2'd3;

    // Half speed reads every sample and repeats it at the DAC side instead.
    function automatic logic [2:0] speed_step(input logic [1:0] spd);
        case (spd)
            SPD_2X:  return 3'd2;
            SPD_4X:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous first-word-fall-through FIFO with flush, shared by the
// playback and record paths.
module sample_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [DATA_W-1:0]           pop_data,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop   = pop && !flush && (count_q != '0);
        // A full FIFO can still take a push in the same cycle it is popped.
        do_push  = push && !flush && ((count_q != DEPTH_C) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

    overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && !flush && (count_q == DEPTH_C)))
        else $error("sample_fifo overflow");

endmodule

// File: rtl/sdram_sample_player.sv
// Streams a sample range from SDRAM into the DAC path with credit-limited
// prefetch, speed selection, pause and abort.
module sdram_sample_player
    import sdram_sample_player_pkg::*;
#(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              play,
    input  logic              pause,
    input  logic [1:0]        speed,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_read,
    input  logic              ram_waitrq,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_valid,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [31:0]       audio_out,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    state_t            state_q, state_d;
    logic              play_q;
    logic [ADDR_W-1:0] addr_q, addr_d, end_q, end_d;
    logic              fetch_end_q, fetch_end_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic              ram_read_q, ram_read_d;
    logic              write_q, write_d;
    logic [31:0]       audio_q, audio_d;
    logic              rep_q, rep_d;

    logic              fifo_push, fifo_pop, fifo_flush, fifo_empty;
    logic [DATA_W-1:0] fifo_data, head;
    logic [CW-1:0]     fifo_count, count_next;
    logic              play_rise, accept, ret, avail, do_write, do_pop, credit_ok;
    logic [2:0]        step;
    logic [ADDR_W:0]   next_sum;

    sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (ram_rdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        play_rise = play && !play_q;
        accept    = ram_read_q && !ram_waitrq;
        ret       = ram_valid && (inflight_q != '0);
        step      = speed_step(speed);
        next_sum  = {1'b0, addr_q} + {{(ADDR_W-2){1'b0}}, step};

        // Returning data bypasses an empty FIFO so the DAC sees it a cycle earlier.
        avail      = !fifo_empty || (ram_valid && state_q == ST_RUN);
        head       = fifo_empty ? ram_rdata : fifo_data;
        do_write   = (state_q == ST_RUN) && play && !pause && audio_out_allowed && avail;
        do_pop     = do_write && ((speed != SPD_HALF) || rep_q);
        fifo_push  = (state_q == ST_RUN) && ram_valid && !(do_pop && fifo_empty);
        fifo_pop   = do_pop && !fifo_empty;
        fifo_flush = (state_q != ST_RUN);

        inflight_d = inflight_q;
        if (accept && !ret)      inflight_d = inflight_q + 1'b1;
        else if (!accept && ret) inflight_d = inflight_q - 1'b1;

        count_next = fifo_count;
        if (fifo_push && !fifo_pop)      count_next = fifo_count + 1'b1;
        else if (!fifo_push && fifo_pop) count_next = fifo_count - 1'b1;
        credit_ok = ({1'b0, count_next} + {1'b0, inflight_d}) < DEPTH_C;

        state_d     = state_q;
        addr_d      = addr_q;
        end_d       = end_q;
        fetch_end_d = fetch_end_q;
        ram_read_d  = 1'b0;
        write_d     = do_write;
        audio_d     = do_write ? {{(32-DATA_W){head[DATA_W-1]}}, head} : audio_q;
        rep_d       = rep_q;
        if (state_q != ST_RUN) rep_d = 1'b0;
        else if (do_write)     rep_d = (speed == SPD_HALF) && !rep_q;

        case (state_q)
            ST_IDLE: begin
                if (play_rise) begin
                    addr_d      = start_addr;
                    end_d       = end_addr;
                    fetch_end_d = 1'b0;
                    state_d     = (start_addr > end_addr) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!play) begin
                    state_d = ST_FLUSH;
                end else begin
                    if (accept) begin
                        addr_d = next_sum[ADDR_W-1:0];
                        if (next_sum > {1'b0, end_q}) fetch_end_d = 1'b1;
                    end
                    // A stalled request is held regardless of pause or credit.
                    if (ram_read_q && ram_waitrq) ram_read_d = 1'b1;
                    else ram_read_d = !fetch_end_d && !pause && credit_ok;
                    if (fetch_end_q && inflight_q == '0 && fifo_empty && !rep_q)
                        state_d = ST_DONE;
                end
            end
            ST_FLUSH: begin
                if (inflight_q == '0) state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (!play) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            play_q      <= 1'b0;
            addr_q      <= '0;
            fetch_end_q <= 1'b0;
            inflight_q  <= '0;
            ram_read_q  <= 1'b0;
            write_q     <= 1'b0;
            audio_q     <= '0;
            rep_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            play_q      <= play;
            addr_q      <= addr_d;
            fetch_end_q <= fetch_end_d;
            inflight_q  <= inflight_d;
            ram_read_q  <= ram_read_d;
            write_q     <= write_d;
            audio_q     <= audio_d;
            rep_q       <= rep_d;
        end
    end

    always_ff @(posedge clk) begin
        end_q <= end_d;
    end

    assign ram_addr        = addr_q;
    assign ram_read        = ram_read_q;
    assign write_audio_out = write_q;
    assign audio_out       = audio_q;
    assign busy            = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done            = (state_q == ST_DONE);

endmodule
